serial_adder: RTL and testbench

- Bit-serial N-bit adder built around one instance of the team's existing full-adder cell FA (S, Co, e1, e2, ci).
- A carry flip-flop closes the FA's Co→ci loop, and shift registers feed operand bits LSB-first.
- It sits directly downstream of FA: it consumes S/Co every clock and assembles them into a word-wide sum.
- It trades latency (WIDTH cycles) for area, and is the next step after the combinational adders in the course sequence.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/FA.sv | 19 +
 rtl/HA.sv | 12 +
 rtl/serial_adder.sv | 93 +++++++++
 tb/tb_serial_adder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and the default width.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int ADD_WIDTH = 8;

  // Bit counter must be able to hold 0..WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/FA.sv
// Full-adder cell built from two half-adders; carry-out is the OR of both partial carries.
module FA (
  output logic S,
  output logic Co,
  input  logic e1,
  input  logic e2,
  input  logic ci
);

  logic s1;
  logic c1;
  logic c2;

  HA u_ha0 (.S(s1), .Co(c1), .e1(e1), .e2(e2));
  HA u_ha1 (.S(S),  .Co(c2), .e1(s1), .e2(ci));

  assign Co = c1 | c2;

endmodule

// File: rtl/HA.sv
// Half-adder cell: the building block of the FA cell.
module HA (
  output logic S,
  output logic Co,
  input  logic e1,
  input  logic e2
);

  assign S  = e1 ^ e2;
  assign Co = e1 & e2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one FA cell, a carry flop closing Co->ci, and LSB-first operand shifters.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] s_next;
  logic             last_bit;

  FA u_fa (
    .S  (fa_s),
    .Co (fa_co),
    .e1 (a_sr[0]),
    .e2 (b_sr[0]),
    .ci (carry)
  );

  // New sum bit enters at the MSB; written with shifts so WIDTH=1 needs no special case.
  assign s_next   = (s_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            s_sr  <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= s_next;
          carry <= fa_co;
          cnt   <= cnt + CNT_W'(1);
          // Outputs are only ever loaded with a complete result.
          if (last_bit) begin
            sum   <= s_next;
            cout  <= fa_co;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, corner sequences, random and exhaustive sweeps.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );
  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  // mode 0: plain, 1: scramble inputs during SHIFT, 2: start pulses mid-SHIFT and on done
  task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                     input logic [8:0] exp, input int mode, input string nm);
    logic [8:0] held;
    @(negedge clk);
    a8 = ai; b8 = bi; cin8 = ci; start8 = 1'b1;
    held = {cout8, sum8};
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check({nm, "_busy"}, {busy8, done8}, 2'b10);
      check({nm, "_hold"}, {cout8, sum8}, held);
      if (mode == 1) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      if (mode == 2 && k == 3) begin
        start8 = 1'b1; a8 = 8'hAA;
      end
      if (mode == 2 && k == 4) start8 = 1'b0;
      @(posedge clk); #1;
    end
    check({nm, "_done"}, {busy8, done8}, 2'b01);
    check({nm, "_res"}, {cout8, sum8}, exp);
    if (mode == 2) start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check({nm, "_idle"}, {busy8, done8, cout8, sum8}, {2'b00, exp});
  endtask

  task automatic sweep4();
    int lat;
    logic [4:0] exp;
    for (int ci = 0; ci < 2; ci++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          exp = 5'(x) + 5'(y) + 5'(ci);
          @(negedge clk);
          a4 = 4'(x); b4 = 4'(y); cin4 = 1'(ci); start4 = 1'b1;
          @(posedge clk); #1;
          start4 = 1'b0;
          lat = 0;
          while (!done4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
          end
          check("w4_lat", lat, 4);
          check("w4_res", {cout4, sum4}, exp);
          @(posedge clk); #1;
        end
  endtask

  task automatic sweep1();
    int lat;
    logic [1:0] exp;
    for (int ci = 0; ci < 2; ci++)
      for (int x = 0; x < 2; x++)
        for (int y = 0; y < 2; y++) begin
          exp = 2'(x) + 2'(y) + 2'(ci);
          @(negedge clk);
          a1 = 1'(x); b1 = 1'(y); cin1 = 1'(ci); start1 = 1'b1;
          @(posedge clk); #1;
          start1 = 1'b0;
          lat = 0;
          while (!done1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
          end
          check("w1_lat", lat, 1);
          check("w1_res", {cout1, sum1}, exp);
          @(posedge clk); #1;
        end
  endtask

  initial begin
    int lat;
    logic [7:0] ra, rb;
    logic       rc;

    tbl[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset8", {busy8, done8, cout8, sum8}, 11'h0);
    check("reset4", {busy4, done4, cout4, sum4}, 7'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      op8(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].exp_cout, tbl[i].exp_sum}, 0, "tbl");

    // Async reset in the middle of SHIFT, between clock edges
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_busy", busy8, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst", {busy8, done8, cout8, sum8}, 11'h0);
    @(negedge clk);
    rst = 1'b0;
    op8(8'h05, 8'h03, 1'b0, 9'h008, 0, "after_rst");

    op8(8'h10, 8'h20, 1'b0, 9'h030, 2, "ign");
    op8(8'hC3, 8'h5A, 1'b1, 9'h11E, 1, "scr");

    // start held high: re-accepted on the first IDLE edge after done
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_lat1", lat, 8);
    check("hold_res1", {cout8, sum8}, 9'h003);
    @(posedge clk); #1;
    check("hold_idle", {busy8, done8}, 2'b00);
    @(posedge clk); #1;
    check("hold_reacc", {busy8, done8}, 2'b10);
    start8 = 1'b0; a8 = 8'h40; b8 = 8'h04;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_lat2", lat, 8);
    check("hold_res2", {cout8, sum8}, 9'h003);
    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      op8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), i % 2, "rand");
    end

    sweep4();
    sweep1();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
